ad9228_frame_align_ctrl: RTL and testbench
==========================================

Name: ad9228_frame_align_ctrl

Overview:
- Frame-alignment controller for one AD9228 LVDS channel. It watches the deserialized FCO word, pulses the ISERDES bitslip until the frame pattern is bit-aligned, then releases the downstream 12-bit gearbox on a frame boundary.
- It holds the gearbox in reset until lock, and monitors for loss of lock.
- Sits between the per-channel ISERDES (data_in_clk = dco_div4 domain) and the gearbox.

Parameters:
- FRAME_PATTERN, 24'hFC0FC0: expected FCO over three consecutive 8-bit words. Words are W0=[23:16], W1=[15:8], W2=[7:0]. W0 starts a 12-bit sample.
- SETTLE_CYCLES, 16: cycles ignored after enable or a bitslip, for ISERDES settling.
- CHECK_WORDS, 48: consecutive predicted-correct words required before lock.
- MAX_SLIPS, 8: bitslips attempted before declaring error; must be ≤15.
- ERR_LIMIT, 4: consecutive mismatched words in LOCKED that drop lock.

Ports:
- data_in_clk  in  1  clock; ISERDES parallel clock.
- rstn  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run alignment, 0 = return to IDLE.
- fco_word  in  8  deserialized FCO, same cycle as the data-lane word.
- bitslip  out  1  one-cycle pulse to the ISERDES.
- gearbox_valid  out  1  data-valid to the gearbox.
- gearbox_rstn  out  1  active-low reset to the gearbox.
- locked  out  1  alignment achieved.
- align_error  out  1  MAX_SLIPS exhausted.
- slip_count  out  4  bitslips issued in the current attempt.

Behaviour:
- All outputs are registered.
- On rstn=0, asynchronously: state=IDLE, all outputs 0 (gearbox_rstn=0 holds the gearbox in reset), all counters 0.
- Phase pointer p (0..2) gives the predicted next word W[p]. On each match, p advances with wrap 2→0.
- enable=0 in any state → IDLE on the next edge; outputs return to reset values except slip_count, which holds.
- IDLE: enable=1 → SETTLE; clear slip_count; load the settle counter.
- SETTLE: count SETTLE_CYCLES cycles, fco_word ignored, then → CHECK with match_cnt=0.
- CHECK, first word:
  - If it equals some Wk: set p=(k+1) mod 3, match_cnt=1.
  - Otherwise → SLIP.
- CHECK, later words:
  - word==W[p]: match_cnt++, p++.
  - Mismatch → SLIP.
  - match_cnt reaches CHECK_WORDS → WAIT_PHASE.
- SLIP:
  - If slip_count==MAX_SLIPS → ERROR, no pulse.
  - Otherwise bitslip=1 for exactly one cycle, slip_count++, → SETTLE.
- WAIT_PHASE:
  - Keep predicting; a mismatch → SLIP.
  - When p==0 and word==W0: next edge sets gearbox_rstn=1, gearbox_valid=1, locked=1 and enters LOCKED.
  - gearbox_valid is therefore one cycle behind the W0 fco_word. The data lane has one register stage upstream of the gearbox to match.
- LOCKED:
  - gearbox_valid=1 continuously; keep predicting.
  - Mismatch: err_cnt++. Match: err_cnt=0.
  - err_cnt reaching ERR_LIMIT → next edge sets locked=0, gearbox_valid=0, gearbox_rstn=0, clears slip_count, → SETTLE. This relocks without a slip.
- ERROR: align_error=1, locked=0, gearbox held in reset. Leave only via enable=0 → IDLE.
- Never more than one bitslip pulse per SETTLE_CYCLES+1 cycles.
- Counter widths are $clog2 of the parameter plus 1; no wrap-around possible.

Optional Feature:
- Macro: AD9228_ALIGN_STATS_EN.
- Defined: adds output relock_count (8 bits), a saturating count of LOCKED→SETTLE transitions. It resets to 0 only on rstn and is not cleared by enable.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Aligned stream FC,0F,C0 repeating, enable=1 → no bitslip; locked=1 within 16+48+4 cycles; slip_count=0; gearbox_valid and gearbox_rstn rise the cycle after an FC word.
- Stream rotated 3 bits, ISERDES model rotates 1 bit per bitslip → exactly 3 one-cycle bitslip pulses ≥17 cycles apart; slip_count=3; then lock.
- fco_word constant 8'h00 → exactly 8 bitslip pulses, then align_error=1, locked=0, gearbox_rstn=0; enable=0 → IDLE, align_error=0.
- In LOCKED, 3 corrupt words then good words → stays locked. 4 consecutive corrupt words → locked, gearbox_valid and gearbox_rstn all 0 on the edge after the 4th, then relock with slip_count=0.
- enable=0 mid-CHECK → IDLE next edge, no bitslip. rstn=0 while LOCKED → all outputs 0 immediately, without waiting for a clock edge.
- With AD9228_ALIGN_STATS_EN defined, force two lock losses → relock_count=2. 300 forced losses → relock_count saturates at 255.

Source files
------------

// File: rtl/ad9228_frame_align_ctrl.sv
// Frame-alignment controller for one AD9228 LVDS channel: bitslips the ISERDES until FCO matches, then releases the gearbox.
// Latency: all outputs registered; gearbox_valid rises one cycle after the W0 FCO word that completes alignment.
// Backpressure: none; consumes one fco_word per data_in_clk. Optional macro AD9228_ALIGN_STATS_EN adds relock_count.
module ad9228_frame_align_ctrl #(
    parameter logic [23:0] FRAME_PATTERN = 24'hFC0FC0,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          CHECK_WORDS   = 48,
    parameter int          MAX_SLIPS     = 8,
    parameter int          ERR_LIMIT     = 4
) (
    input  logic       data_in_clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic [7:0] fco_word,
    output logic       bitslip,
    output logic       gearbox_valid,
    output logic       gearbox_rstn,
    output logic       locked,
    output logic       align_error,
    output logic [3:0] slip_count
`ifdef AD9228_ALIGN_STATS_EN
    ,
    output logic [7:0] relock_count
`endif
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int MW = $clog2(CHECK_WORDS) + 1;
    localparam int EW = $clog2(ERR_LIMIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_WAIT_PHASE,
        S_LOCKED,
        S_ERROR
    } state_t;

    // Frame words in arrival order; W0 starts a 12-bit sample.
    logic [7:0] w_w0, w_w1, w_w2;
    assign w_w0 = FRAME_PATTERN[23:16];
    assign w_w1 = FRAME_PATTERN[15:8];
    assign w_w2 = FRAME_PATTERN[7:0];

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_phase, w_phase_nxt;
    logic [SW-1:0] r_settle_cnt, w_settle_nxt;
    logic [MW-1:0] r_match_cnt, w_match_nxt;
    logic [EW-1:0] r_err_cnt, w_err_nxt;
    logic [3:0]    r_slip_count, w_slip_nxt;
    logic          r_bitslip, w_bitslip_nxt;
    logic          r_gearbox_valid, w_gb_valid_nxt;
    logic          r_gearbox_rstn, w_gb_rstn_nxt;
    logic          r_locked, w_locked_nxt;
    logic          r_align_error, w_align_err_nxt;

    logic [7:0]    w_pred;
    logic          w_match;
    logic          w_hit;
    logic [1:0]    w_hit_phase;
    logic [MW-1:0] w_match_inc;
    logic [EW-1:0] w_err_inc;
    logic          w_first;
    logic          w_check_ok;
    logic [1:0]    w_check_phase;

    function automatic logic [1:0] f_next_phase(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Predicted word for the current phase and first-word phase acquisition.
    always_comb begin
        w_pred      = w_w0;
        w_hit       = 1'b0;
        w_hit_phase = 2'd0;
        case (r_phase)
            2'd1:    w_pred = w_w1;
            2'd2:    w_pred = w_w2;
            default: w_pred = w_w0;
        endcase
        if (fco_word == w_w0) begin
            w_hit       = 1'b1;
            w_hit_phase = 2'd1;
        end else if (fco_word == w_w1) begin
            w_hit       = 1'b1;
            w_hit_phase = 2'd2;
        end else if (fco_word == w_w2) begin
            w_hit       = 1'b1;
            w_hit_phase = 2'd0;
        end
    end

    assign w_match       = (fco_word == w_pred);
    assign w_match_inc   = r_match_cnt + MW'(1);
    assign w_err_inc     = r_err_cnt + EW'(1);
    // A zero match count marks the first word of a CHECK pass: any frame word is accepted and sets the phase.
    assign w_first       = (r_match_cnt == '0);
    assign w_check_ok    = w_first ? w_hit : w_match;
    assign w_check_phase = w_first ? w_hit_phase : f_next_phase(r_phase);

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_settle_nxt    = r_settle_cnt;
        w_match_nxt     = r_match_cnt;
        w_err_nxt       = r_err_cnt;
        w_slip_nxt      = r_slip_count;
        w_bitslip_nxt   = 1'b0;
        w_gb_valid_nxt  = r_gearbox_valid;
        w_gb_rstn_nxt   = r_gearbox_rstn;
        w_locked_nxt    = r_locked;
        w_align_err_nxt = r_align_error;

        if (!enable) begin
            // slip_count is kept so software can read the last attempt after disabling.
            w_state_nxt     = S_IDLE;
            w_phase_nxt     = 2'd0;
            w_settle_nxt    = '0;
            w_match_nxt     = '0;
            w_err_nxt       = '0;
            w_gb_valid_nxt  = 1'b0;
            w_gb_rstn_nxt   = 1'b0;
            w_locked_nxt    = 1'b0;
            w_align_err_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt  = S_SETTLE;
                    w_slip_nxt   = 4'd0;
                    w_settle_nxt = SW'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        w_state_nxt = S_CHECK;
                        w_match_nxt = '0;
                        w_err_nxt   = '0;
                    end else begin
                        w_settle_nxt = r_settle_cnt - SW'(1);
                    end
                end
                S_CHECK: begin
                    if (w_check_ok) begin
                        w_phase_nxt = w_check_phase;
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == MW'(CHECK_WORDS)) begin
                            w_state_nxt = S_WAIT_PHASE;
                        end
                    end else begin
                        w_state_nxt = S_SLIP;
                    end
                end
                S_SLIP: begin
                    if (r_slip_count == 4'(MAX_SLIPS)) begin
                        w_state_nxt     = S_ERROR;
                        w_align_err_nxt = 1'b1;
                    end else begin
                        w_bitslip_nxt = 1'b1;
                        w_slip_nxt    = r_slip_count + 4'd1;
                        w_state_nxt   = S_SETTLE;
                        w_settle_nxt  = SW'(SETTLE_CYCLES - 1);
                    end
                end
                S_WAIT_PHASE: begin
                    if (w_match) begin
                        w_phase_nxt = f_next_phase(r_phase);
                        if (r_phase == 2'd0) begin
                            w_state_nxt    = S_LOCKED;
                            w_gb_valid_nxt = 1'b1;
                            w_gb_rstn_nxt  = 1'b1;
                            w_locked_nxt   = 1'b1;
                            w_err_nxt      = '0;
                        end
                    end else begin
                        w_state_nxt = S_SLIP;
                    end
                end
                S_LOCKED: begin
                    // The link keeps delivering one word per cycle, so the phase advances on corrupt words too.
                    w_phase_nxt = f_next_phase(r_phase);
                    if (w_match) begin
                        w_err_nxt = '0;
                    end else if (w_err_inc == EW'(ERR_LIMIT)) begin
                        w_state_nxt    = S_SETTLE;
                        w_settle_nxt   = SW'(SETTLE_CYCLES - 1);
                        w_slip_nxt     = 4'd0;
                        w_err_nxt      = '0;
                        w_gb_valid_nxt = 1'b0;
                        w_gb_rstn_nxt  = 1'b0;
                        w_locked_nxt   = 1'b0;
                    end else begin
                        w_err_nxt = w_err_inc;
                    end
                end
                S_ERROR: begin
                    w_align_err_nxt = 1'b1;
                    w_locked_nxt    = 1'b0;
                    w_gb_valid_nxt  = 1'b0;
                    w_gb_rstn_nxt   = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and registered-output update with asynchronous active-low reset.
    always_ff @(posedge data_in_clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_phase         <= 2'd0;
            r_settle_cnt    <= '0;
            r_match_cnt     <= '0;
            r_err_cnt       <= '0;
            r_slip_count    <= 4'd0;
            r_bitslip       <= 1'b0;
            r_gearbox_valid <= 1'b0;
            r_gearbox_rstn  <= 1'b0;
            r_locked        <= 1'b0;
            r_align_error   <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_phase         <= w_phase_nxt;
            r_settle_cnt    <= w_settle_nxt;
            r_match_cnt     <= w_match_nxt;
            r_err_cnt       <= w_err_nxt;
            r_slip_count    <= w_slip_nxt;
            r_bitslip       <= w_bitslip_nxt;
            r_gearbox_valid <= w_gb_valid_nxt;
            r_gearbox_rstn  <= w_gb_rstn_nxt;
            r_locked        <= w_locked_nxt;
            r_align_error   <= w_align_err_nxt;
        end
    end

    assign bitslip       = r_bitslip;
    assign gearbox_valid = r_gearbox_valid;
    assign gearbox_rstn  = r_gearbox_rstn;
    assign locked        = r_locked;
    assign align_error   = r_align_error;
    assign slip_count    = r_slip_count;

`ifdef AD9228_ALIGN_STATS_EN
    logic       w_relock_evt;
    logic [7:0] r_relock_count;

    assign w_relock_evt = (r_state == S_LOCKED) && (w_state_nxt == S_SETTLE);

    // Saturating count of lock losses; only rstn clears it, enable does not.
    always_ff @(posedge data_in_clk or negedge rstn) begin
        if (!rstn) begin
            r_relock_count <= 8'd0;
        end else if (w_relock_evt && (r_relock_count != 8'hFF)) begin
            r_relock_count <= r_relock_count + 8'd1;
        end
    end

    assign relock_count = r_relock_count;
`endif

endmodule

// File: tb/tb_ad9228_frame_align_ctrl.sv
// Bench for ad9228_frame_align_ctrl: serial FCO stream model with bitslip, corruption bursts, error and reset cases.
// The serial FCO is a 12-bit periodic pattern (six ones, six zeros); a word is an 8-bit window of it.
// Alignment holds whenever the window start is a multiple of 4 bits, so required slips = (4 - offset%4) % 4.
module tb_ad9228_frame_align_ctrl;

    logic       data_in_clk = 1'b0;
    logic       rstn        = 1'b0;
    logic       enable      = 1'b0;
    logic [7:0] fco_word    = 8'h00;
    logic       bitslip;
    logic       gearbox_valid;
    logic       gearbox_rstn;
    logic       locked;
    logic       align_error;
    logic [3:0] slip_count;
`ifdef AD9228_ALIGN_STATS_EN
    logic [7:0] relock_count;
`endif

    ad9228_frame_align_ctrl dut (
        .data_in_clk   (data_in_clk),
        .rstn          (rstn),
        .enable        (enable),
        .fco_word      (fco_word),
        .bitslip       (bitslip),
        .gearbox_valid (gearbox_valid),
        .gearbox_rstn  (gearbox_rstn),
        .locked        (locked),
        .align_error   (align_error),
        .slip_count    (slip_count)
`ifdef AD9228_ALIGN_STATS_EN
        ,
        .relock_count  (relock_count)
`endif
    );

    always #5 data_in_clk = ~data_in_clk;

    int         n_asrt      = 0;
    int         n_fail      = 0;
    int         pos         = 0;
    int         cyc         = 0;
    int         corrupt_left = 0;
    int         n_pulses    = 0;
    int         last_pulse  = 0;
    logic       valid_d     = 1'b0;
    logic       const_mode  = 1'b0;
    logic [7:0] const_val   = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial FCO bit at absolute position i: high for the first six bits of every twelve.
    function automatic logic [7:0] gen_word(input int p);
        logic [7:0] w;
        for (int b = 0; b < 8; b++) begin
            w[7-b] = (((p + b) % 12) < 6);
        end
        return w;
    endfunction

    // One clock: observe outputs at the falling edge, model the ISERDES slip, drive the next word.
    task automatic tick();
        @(negedge data_in_clk);
        cyc++;
        if (bitslip === 1'b1) begin
            if (n_pulses > 0) check("slip_gap_ge17", 32'((cyc - last_pulse) >= 17), 32'd1);
            n_pulses++;
            last_pulse = cyc;
            pos += 1;
        end
        if (gearbox_valid === 1'b1 && valid_d !== 1'b1) begin
            check("valid_after_fc", 32'(fco_word), 32'hFC);
            check("gbrstn_with_valid", 32'(gearbox_rstn), 32'd1);
        end
        valid_d = gearbox_valid;
        pos += 8;
        if (const_mode) begin
            fco_word = const_val;
        end else if (corrupt_left > 0) begin
            fco_word = ~gen_word(pos);
            corrupt_left--;
        end else begin
            fco_word = gen_word(pos);
        end
    endtask

    task automatic wait_lock(input int budget, output int took);
        took = 0;
        while (locked !== 1'b1 && took < budget) begin
            tick();
            took++;
        end
        check("lock_reached", 32'(locked), 32'd1);
    endtask

    // Disable, then start a fresh attempt with the stream window at bit offset o.
    task automatic restart(input int o);
        enable = 1'b0;
        tick();
        check("idle_locked", 32'(locked), 32'd0);
        check("idle_gbrstn", 32'(gearbox_rstn), 32'd0);
        pos      = o + 4;
        n_pulses = 0;
        enable   = 1'b1;
    endtask

    task automatic force_loss();
        corrupt_left = 4;
        repeat (5) tick();
        check("loss_locked", 32'(locked), 32'd0);
    endtask

    initial begin
        int took;
        int o;
        int len;
        int exp_slips;
        logic dropped;

        // Reset state.
        repeat (3) tick();
        check("rst_bitslip", 32'(bitslip), 32'd0);
        check("rst_valid", 32'(gearbox_valid), 32'd0);
        check("rst_gbrstn", 32'(gearbox_rstn), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_align_error", 32'(align_error), 32'd0);
        check("rst_slip_count", 32'(slip_count), 32'd0);
`ifdef AD9228_ALIGN_STATS_EN
        check("rst_relock_count", 32'(relock_count), 32'd0);
`endif
        rstn = 1'b1;
        tick();

        // Aligned stream: no slips, lock within 16+48+4 cycles.
        n_pulses = 0;
        enable   = 1'b1;
        wait_lock(200, took);
        check("aligned_latency_le68", 32'(took <= 68), 32'd1);
        check("aligned_pulses", 32'(n_pulses), 32'd0);
        check("aligned_slip_count", 32'(slip_count), 32'd0);
        check("aligned_valid", 32'(gearbox_valid), 32'd1);
        check("aligned_gbrstn", 32'(gearbox_rstn), 32'd1);

        // Three corrupt words are tolerated.
        corrupt_left = 3;
        dropped = 1'b0;
        repeat (20) begin
            tick();
            if (locked !== 1'b1) dropped = 1'b1;
        end
        check("burst3_no_drop", 32'(dropped), 32'd0);

        // Four corrupt words drop lock on the edge after the fourth, then relock without a slip.
        corrupt_left = 4;
        repeat (4) tick();
        check("burst4_still_locked", 32'(locked), 32'd1);
        tick();
        check("burst4_locked", 32'(locked), 32'd0);
        check("burst4_valid", 32'(gearbox_valid), 32'd0);
        check("burst4_gbrstn", 32'(gearbox_rstn), 32'd0);
        n_pulses = 0;
        wait_lock(200, took);
        check("relock_slip_count", 32'(slip_count), 32'd0);
        check("relock_pulses", 32'(n_pulses), 32'd0);

        // Stream rotated three bits: three slips, then lock.
        restart(9);
        wait_lock(400, took);
        check("rot3_pulses", 32'(n_pulses), 32'd3);
        check("rot3_slip_count", 32'(slip_count), 32'd3);

        // Random offsets and random corruption bursts.
        for (int t = 0; t < 6; t++) begin
            o = int'($urandom_range(0, 11));
            exp_slips = (4 - (o % 4)) % 4;
            restart(o);
            wait_lock(400, took);
            check("rand_pulses", 32'(n_pulses), 32'(exp_slips));
            check("rand_slip_count", 32'(slip_count), 32'(exp_slips));
            len = int'($urandom_range(1, 4));
            corrupt_left = len;
            repeat (len + 1) tick();
            check("rand_burst_locked", 32'(locked), 32'(len < 4));
            if (len >= 4) begin
                wait_lock(200, took);
                check("rand_relock_slip_count", 32'(slip_count), 32'd0);
            end
        end

        // enable=0 in the middle of CHECK: back to IDLE, no bitslip.
        restart(0);
        repeat (27) tick();
        check("midcheck_not_locked", 32'(locked), 32'd0);
        enable = 1'b0;
        tick();
        check("midcheck_bitslip", 32'(bitslip), 32'd0);
        repeat (40) tick();
        check("midcheck_pulses", 32'(n_pulses), 32'd0);
        check("midcheck_locked", 32'(locked), 32'd0);

        // Constant 00: eight slips, then error until disabled.
        const_mode = 1'b1;
        const_val  = 8'h00;
        n_pulses   = 0;
        enable     = 1'b1;
        took = 0;
        while (align_error !== 1'b1 && took < 600) begin
            tick();
            took++;
        end
        check("err_align_error", 32'(align_error), 32'd1);
        check("err_pulses", 32'(n_pulses), 32'd8);
        check("err_slip_count", 32'(slip_count), 32'd8);
        check("err_locked", 32'(locked), 32'd0);
        check("err_gbrstn", 32'(gearbox_rstn), 32'd0);
        repeat (30) tick();
        check("err_sticky", 32'(align_error), 32'd1);
        check("err_no_more_pulses", 32'(n_pulses), 32'd8);
        enable = 1'b0;
        tick();
        check("err_cleared", 32'(align_error), 32'd0);
        check("err_slip_count_held", 32'(slip_count), 32'd8);
        const_mode = 1'b0;

        // Asynchronous reset while locked.
        restart(0);
        wait_lock(200, took);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_valid", 32'(gearbox_valid), 32'd0);
        check("arst_gbrstn", 32'(gearbox_rstn), 32'd0);
        check("arst_slip_count", 32'(slip_count), 32'd0);
        enable = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

`ifdef AD9228_ALIGN_STATS_EN
        check("stats_after_rst", 32'(relock_count), 32'd0);
        restart(0);
        wait_lock(200, took);
        force_loss();
        wait_lock(200, took);
        force_loss();
        wait_lock(200, took);
        check("stats_two_losses", 32'(relock_count), 32'd2);
        restart(0);
        check("stats_not_cleared_by_enable", 32'(relock_count), 32'd2);
        wait_lock(200, took);
        for (int i = 0; i < 298; i++) begin
            corrupt_left = 4;
            repeat (5) tick();
            wait_lock(200, took);
        end
        check("stats_saturated", 32'(relock_count), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
